// File: rtl/rf_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pulse_pkg
// Purpose  : Shared state encoding and default sizing for the FSK burst generator.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } rf_state_e;

    localparam int c_def_cnt_w        = 8;
    localparam int c_def_burst_cycles = 64;
    localparam int c_def_gap_cycles   = 16;

endpackage
`default_nettype wire

// File: rtl/rf_carrier_div.sv
`default_nettype none
// ============================================================================
// Module   : rf_carrier_div
// Purpose  : Half-period divider producing the burst carrier; hp captured on load.
// Revision : 1.0 - initial release
// ============================================================================
module rf_carrier_div #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] hp,
    output logic             carrier
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
    logic             carrier_q, carrier_d;

    always_comb begin
        hp_d      = hp_q;
        car_cnt_d = car_cnt_q;
        carrier_d = carrier_q;
        if (load) begin
            // A zero half-period would never toggle; treat it as the fastest carrier.
            hp_d      = (hp == '0) ? c_one : hp;
            car_cnt_d = '0;
            carrier_d = 1'b1;
        end else if (run) begin
            if (car_cnt_q == hp_q - c_one) begin
                car_cnt_d = '0;
                carrier_d = ~carrier_q;
            end else begin
                car_cnt_d = car_cnt_q + c_one;
            end
        end else begin
            car_cnt_d = '0;
            carrier_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q      <= '0;
            car_cnt_q <= '0;
            carrier_q <= 1'b0;
        end else begin
            hp_q      <= hp_d;
            car_cnt_q <= car_cnt_d;
            carrier_q <= carrier_d;
        end
    end

    assign carrier = carrier_q;

endmodule
`default_nettype wire

// File: rtl/rf_fsk_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : rf_fsk_burst_gen
// Purpose  : One fixed-length FSK carrier burst per accepted symbol, then a guard gap.
// Revision : 1.0 - initial release
// ============================================================================
module rf_fsk_burst_gen
    import rf_pulse_pkg::*;
#(
    parameter int CNT_W        = c_def_cnt_w,
    parameter int BURST_CYCLES = c_def_burst_cycles,
    parameter int GAP_CYCLES   = c_def_gap_cycles
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic             sym_bit,
    input  logic [CNT_W-1:0] half_per0,
    input  logic [CNT_W-1:0] half_per1,
    input  logic             abort,
    output logic             rf_out,
    output logic             burst_active,
    output logic             sym_done
);

    localparam int c_bw = $clog2(BURST_CYCLES + 1);
    localparam int c_gw = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [c_bw-1:0] c_burst_last = c_bw'(BURST_CYCLES - 1);
    localparam logic [c_gw-1:0] c_gap_last   = c_gw'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    generate
        if (BURST_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
            $error("rf_fsk_burst_gen: BURST_CYCLES and CNT_W must be >= 1");
        end
    endgenerate

    rf_state_e        state_q, state_d;
    logic [c_bw-1:0]  burst_cnt_q, burst_cnt_d;
    logic [c_gw-1:0]  gap_cnt_q, gap_cnt_d;
    logic             sym_done_q, sym_done_d;

    logic             w_load;
    logic             w_carrier;
    logic [CNT_W-1:0] w_hp_sel;

    assign sym_ready    = (state_q == IDLE);
    assign burst_active = (state_q == BURST);
    assign sym_done     = sym_done_q;
    assign rf_out       = w_carrier & burst_active;

    assign w_load   = sym_valid & sym_ready & ~abort;
    assign w_hp_sel = sym_bit ? half_per1 : half_per0;

    rf_carrier_div #(
        .CNT_W (CNT_W)
    ) u_carrier_div (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .run     (burst_active),
        .hp      (w_hp_sel),
        .carrier (w_carrier)
    );

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sym_done_d  = 1'b0;
        if (abort) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
            gap_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_load) begin
                        state_d     = BURST;
                        burst_cnt_d = '0;
                    end
                end
                BURST: begin
                    if (burst_cnt_q == c_burst_last) begin
                        state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
                        burst_cnt_d = '0;
                        gap_cnt_d   = '0;
                        sym_done_d  = 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + c_bw'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == c_gap_last) begin
                        state_d   = IDLE;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + c_gw'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    gap_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            sym_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sym_done_q  <= sym_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_fsk_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_fsk_burst_gen
// Purpose  : Self-checking bench; expected carrier computed from burst index and hp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_fsk_burst_gen;

    localparam int B  = 8;
    localparam int G  = 4;
    localparam int B2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       sym_valid = 1'b0, sym_bit = 1'b0, abort = 1'b0;
    logic [7:0] half_per0 = 8'd0, half_per1 = 8'd0;
    logic       sym_ready, rf_out, burst_active, sym_done;

    logic       b_sym_valid = 1'b0, b_sym_bit = 1'b0, b_abort = 1'b0;
    logic [7:0] b_half_per0 = 8'd0, b_half_per1 = 8'd0;
    logic       b_sym_ready, b_rf_out, b_burst_active, b_sym_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_fsk_burst_gen #(.CNT_W(8), .BURST_CYCLES(B), .GAP_CYCLES(G)) u_dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_bit(sym_bit), .half_per0(half_per0), .half_per1(half_per1),
        .abort(abort), .rf_out(rf_out), .burst_active(burst_active), .sym_done(sym_done)
    );

    rf_fsk_burst_gen #(.CNT_W(8), .BURST_CYCLES(B2), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .rst(rst), .sym_valid(b_sym_valid), .sym_ready(b_sym_ready),
        .sym_bit(b_sym_bit), .half_per0(b_half_per0), .half_per1(b_half_per1),
        .abort(b_abort), .rf_out(b_rf_out), .burst_active(b_burst_active), .sym_done(b_sym_done)
    );

    // Square wave starting high: half-period index k/hp even -> high.
    function automatic logic model_rf(input int k, input int hp);
        int h;
        h = (hp == 0) ? 1 : hp;
        return ((k / h) % 2) == 0;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (sym_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: sym_ready=%b after %0d cycles, want 1", sym_ready, budget);
        end
    endtask

    task automatic send_and_check(input logic b, input logic [7:0] hp0, input logic [7:0] hp1,
                                  input string tag, output logic [B-1:0] cap);
        int hp;
        hp = b ? int'(hp1) : int'(hp0);
        cap = '0;
        wait_idle(40);
        sym_bit = b; half_per0 = hp0; half_per1 = hp1; sym_valid = 1'b1;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        sym_bit   = 1'($urandom);
        half_per0 = 8'($urandom);
        half_per1 = 8'($urandom);
        for (int k = 0; k < B; k++) begin
            @(negedge clk);
            cap[B-1-k] = rf_out;
            checks++;
            if (rf_out !== model_rf(k, hp) || burst_active !== 1'b1 || sym_done !== 1'b0 || sym_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s burst cyc %0d hp=%0d: rf_out=%b ba=%b done=%b rdy=%b, want rf_out=%b ba=1 done=0 rdy=0",
                         tag, k, hp, rf_out, burst_active, sym_done, sym_ready, model_rf(k, hp));
            end
        end
        @(negedge clk);
        checks++;
        if (rf_out !== 1'b0 || burst_active !== 1'b0 || sym_done !== 1'b1 || sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s end: rf_out=%b ba=%b done=%b rdy=%b, want 0 0 1 0",
                     tag, rf_out, burst_active, sym_done, sym_ready);
        end
        for (int g = 1; g < G; g++) begin
            @(negedge clk);
            checks++;
            if (rf_out !== 1'b0 || burst_active !== 1'b0 || sym_done !== 1'b0 || sym_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s gap cyc %0d: rf_out=%b ba=%b done=%b rdy=%b, want 0 0 0 0",
                         tag, g, rf_out, burst_active, sym_done, sym_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready after gap: sym_ready=%b, want 1", tag, sym_ready);
        end
    endtask

    task automatic test_reset();
        int done_seen;
        repeat (2) @(negedge clk);
        checks++;
        if (rf_out !== 1'b0 || burst_active !== 1'b0 || sym_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rf_out=%b ba=%b done=%b, want 0 0 0", rf_out, burst_active, sym_done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b1 || b_sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: sym_ready=%b b_sym_ready=%b, want 1 1", sym_ready, b_sym_ready);
        end
        sym_bit = 1'b0; half_per0 = 8'd2; sym_valid = 1'b1;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rf_out !== 1'b1 || burst_active !== 1'b1) begin
            errors++;
            $display("FAIL reset_preburst: rf_out=%b ba=%b, want 1 1", rf_out, burst_active);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rf_out !== 1'b0 || burst_active !== 1'b0 || sym_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rf_out=%b ba=%b done=%b, want 0 0 0", rf_out, burst_active, sym_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b1 || burst_active !== 1'b0 || rf_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: rdy=%b ba=%b rf_out=%b, want 1 0 0", sym_ready, burst_active, rf_out);
        end
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (sym_done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: sym_done pulses=%0d, want 0", done_seen);
        end
    endtask

    task automatic test_fixed_vectors();
        logic [B-1:0] cap;
        send_and_check(1'b0, 8'd2, 8'd7, "hp2", cap);
        checks++;
        if (cap !== 8'b1100_1100) begin
            errors++;
            $display("FAIL hp2_pattern: got %b, want 11001100", cap);
        end
        send_and_check(1'b1, 8'd9, 8'd3, "hp3_trunc", cap);
        checks++;
        if (cap !== 8'b1110_0011) begin
            errors++;
            $display("FAIL hp3_pattern: got %b, want 11100011", cap);
        end
    endtask

    task automatic test_random();
        logic [B-1:0] cap;
        logic         b;
        logic [7:0]   h0, h1;
        for (int i = 0; i < 16; i++) begin
            b  = 1'($urandom_range(0, 1));
            h0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            h1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            send_and_check(b, h0, h1, "random", cap);
        end
    endtask

    task automatic test_back_to_back();
        int   rise[$];
        logic rfh[0:39];
        logic prev_ba;
        wait_idle(40);
        half_per0 = 8'd2; half_per1 = 8'd3; sym_bit = 1'b0; sym_valid = 1'b1;
        prev_ba = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            rfh[t] = rf_out;
            if (burst_active === 1'b1 && prev_ba === 1'b0) begin
                rise.push_back(t);
                if (rise.size() == 1) sym_bit = 1'b1;
                if (rise.size() == 2) sym_valid = 1'b0;
            end
            if (rise.size() == 1 && t == rise[0] + 2) half_per0 = 8'd5;
            prev_ba = burst_active;
        end
        sym_valid = 1'b0;
        checks++;
        if (rise.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d, want 2", rise.size());
        end else begin
            checks++;
            if (rise[1] - rise[0] != B + G + 1) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles, want %0d", rise[1] - rise[0], B + G + 1);
            end
            for (int k = 0; k < B; k++) begin
                checks++;
                if (rise[0] + k < 40 && rfh[rise[0] + k] !== model_rf(k, 2)) begin
                    errors++;
                    $display("FAIL b2b_burst0 cyc %0d: rf_out=%b, want %b", k, rfh[rise[0] + k], model_rf(k, 2));
                end
                checks++;
                if (rise[1] + k < 40 && rfh[rise[1] + k] !== model_rf(k, 3)) begin
                    errors++;
                    $display("FAIL b2b_burst1 cyc %0d: rf_out=%b, want %b", k, rfh[rise[1] + k], model_rf(k, 3));
                end
            end
        end
    endtask

    task automatic test_abort();
        wait_idle(40);
        sym_bit = 1'($urandom_range(0, 1));
        half_per0 = 8'($urandom_range(1, 4)); half_per1 = 8'($urandom_range(1, 4));
        sym_valid = 1'b1;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_out !== 1'b0 || burst_active !== 1'b0 || sym_done !== 1'b0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_burst: rf_out=%b ba=%b done=%b rdy=%b, want 0 0 0 1",
                     rf_out, burst_active, sym_done, sym_ready);
        end
        sym_bit = 1'b1; half_per1 = 8'd1; sym_valid = 1'b1;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (burst_active !== 1'b1 || rf_out !== 1'b1) begin
            errors++;
            $display("FAIL abort_reaccept: ba=%b rf_out=%b, want 1 1", burst_active, rf_out);
        end
        wait_idle(40);
        sym_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (burst_active !== 1'b0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_block: ba=%b rdy=%b, want 0 1", burst_active, sym_ready);
        end
        abort = 1'b0;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (burst_active !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_release: ba=%b, want 1", burst_active);
        end
        repeat (B + 1) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b1 || rf_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_gap: rdy=%b rf_out=%b, want 1 0", sym_ready, rf_out);
        end
    endtask

    task automatic test_clamp_nogap();
        logic [B2-1:0] cap;
        b_half_per0 = 8'd0; b_half_per1 = 8'd6; b_sym_bit = 1'b0; b_sym_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < B2; k++) begin
            @(negedge clk);
            cap[B2-1-k] = b_rf_out;
        end
        checks++;
        if (cap !== 4'b1010) begin
            errors++;
            $display("FAIL clamp_pattern: got %b, want 1010", cap);
        end
        @(negedge clk);
        checks++;
        if (b_sym_done !== 1'b1 || b_sym_ready !== 1'b1 || b_burst_active !== 1'b0 || b_rf_out !== 1'b0) begin
            errors++;
            $display("FAIL nogap_end: done=%b rdy=%b ba=%b rf_out=%b, want 1 1 0 0",
                     b_sym_done, b_sym_ready, b_burst_active, b_rf_out);
        end
        @(negedge clk);
        b_sym_valid = 1'b0;
        checks++;
        if (b_burst_active !== 1'b1 || b_sym_done !== 1'b0) begin
            errors++;
            $display("FAIL nogap_reaccept: ba=%b done=%b, want 1 0", b_burst_active, b_sym_done);
        end
        repeat (B2 + 2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed_vectors();
        test_random();
        test_back_to_back();
        test_abort();
        test_clamp_nogap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
